// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU
// between two requesters, with registered operands and a tagged response.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             rid_q, rid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flg_q, flg_d;

    logic gnt_vld;
    logic gnt_id;
    logic idle;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req1_valid;
        end
    end

    assign idle       = (state_q == IDLE);
    assign req0_ready = idle & gnt_vld & ~gnt_id;
    assign req1_ready = idle & gnt_vld & gnt_id;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        rid_d   = rid_q;
        res_d   = res_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    ctrl_d  = gnt_id ? req1_ctrl : req0_ctrl;
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                flg_d   = alu_flags;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 2'b00;
            rid_q   <= 1'b0;
            res_q   <= '0;
            flg_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            rid_q   <= rid_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rid_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized + directed bench with an external ALU model
// and a transaction-level scoreboard for arbitration and responses.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_ctrl;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    // ARM ALU: {N,Z,C,V, result}
    function automatic logic [35:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [1:0]  c);
        logic [32:0] s;
        logic [31:0] bb, r;
        logic        n, z, cy, v;
        bb = (c == 2'b01) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + 33'(c == 2'b01);
        case (c)
            2'b10:   r = a & b;
            2'b11:   r = a | b;
            default: r = s[31:0];
        endcase
        n  = r[31];
        z  = (r == 32'd0);
        cy = ~c[1] & s[32];
        v  = ~c[1] & (a[31] == bb[31]) & (s[31] != a[31]);
        return {n, z, cy, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
    } op_t;

    op_t         q[$];
    bit          grants[$];
    bit          rids[$];
    bit          busy;
    bit          last_gnt;
    int          cyc, hs_cyc, cons_cyc, nresp;
    int          n_chk, n_pass;
    bit          r_id;
    logic [31:0] r_res;
    logic [3:0]  r_flg;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        busy     = 0;
        last_gnt = 1;
        hs_cyc   = -100;
        q.delete();
    endtask

    // One clock: check at negedge, then drop accepted valids after posedge.
    task automatic step();
        logic  e0, e1;
        logic [35:0] er;
        bit    h0, h1;
        op_t   o;
        h0 = 0;
        h1 = 0;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            e0 = !busy && req0_valid && (!req1_valid || last_gnt);
            e1 = !busy && req1_valid && (!req0_valid || !last_gnt);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("rsp_valid", 32'(rsp_valid),
                32'(busy && cyc >= hs_cyc + 2));
            if (busy && cyc == hs_cyc + 1) begin
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_ctrl", 32'(alu_ctrl), 32'(q[0].c));
            end
            if (busy && rsp_valid) begin
                er = alu_ref(q[0].a, q[0].b, q[0].c);
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_result", rsp_result, er[31:0]);
                chk("rsp_flags", 32'(rsp_flags), 32'(er[35:32]));
                if (rsp_ready) begin
                    r_id  = rsp_id;
                    r_res = rsp_result;
                    r_flg = rsp_flags;
                    rids.push_back(rsp_id);
                    void'(q.pop_front());
                    busy     = 0;
                    cons_cyc = cyc;
                    nresp++;
                end
            end
            if (req0_valid && req0_ready) begin
                o = '{id: 1'b0, a: req0_a, b: req0_b, c: req0_ctrl};
                h0 = 1;
            end else if (req1_valid && req1_ready) begin
                o = '{id: 1'b1, a: req1_a, b: req1_b, c: req1_ctrl};
                h1 = 1;
            end
            if (h0 || h1) begin
                q.push_back(o);
                grants.push_back(o.id);
                busy     = 1;
                hs_cyc   = cyc;
                last_gnt = o.id;
            end
        end
        @(posedge clk);
        #1;
        if (h0) req0_valid = 0;
        if (h1) req1_valid = 0;
    endtask

    task automatic issue(input bit id, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] c);
        if (!id) begin
            req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1;
        end else begin
            req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1;
        end
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 40 && nresp < target; i++) step();
        if (nresp < target) chk("resp_timeout", 32'(nresp), 32'(target));
    endtask

    task automatic apply_reset();
        reset      = 1;
        req0_valid = 0;
        req1_valid = 0;
        #1;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int t;
        reset = 1; rsp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_ctrl = 0;
        req1_a = 0; req1_b = 0; req1_ctrl = 0;
        n_chk = 0; n_pass = 0; cyc = 0; nresp = 0; cons_cyc = -100;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        issue(0, 32'd5, 32'd3, 2'b00);
        wait_resp(1);
        chk("add_id", 32'(r_id), 32'd0);
        chk("add_res", r_res, 32'd8);
        chk("add_flags", 32'(r_flg), 32'b0000);

        issue(1, 32'd5, 32'd5, 2'b01);
        wait_resp(2);
        chk("sub_id", 32'(r_id), 32'd1);
        chk("sub_res", r_res, 32'd0);
        chk("sub_flags", 32'(r_flg), 32'b0110);

        issue(0, 32'h7FFF_FFFF, 32'd1, 2'b00);
        wait_resp(3);
        chk("ovf_res", r_res, 32'h8000_0000);
        chk("ovf_flags", 32'(r_flg), 32'b1001);

        apply_reset();
        grants.delete();
        rids.delete();
        for (int i = 0; i < 40 && grants.size() < 3; i++) begin
            if (!req0_valid) issue(0, $urandom, $urandom, 2'($urandom));
            if (!req1_valid) issue(1, $urandom, $urandom, 2'($urandom));
            step();
        end
        wait_resp(nresp + (busy ? 1 : 0));
        req0_valid = 0;
        req1_valid = 0;
        if (grants.size() >= 3 && rids.size() >= 3) begin
            chk("rr_g0", 32'(grants[0]), 32'd0);
            chk("rr_g1", 32'(grants[1]), 32'd1);
            chk("rr_g2", 32'(grants[2]), 32'd0);
            chk("rr_r0", 32'(rids[0]), 32'd0);
            chk("rr_r1", 32'(rids[1]), 32'd1);
            chk("rr_r2", 32'(rids[2]), 32'd0);
        end else begin
            chk("rr_count", 32'(rids.size()), 32'd3);
        end

        grants.delete();
        for (int k = 0; k < 3; k++) begin
            issue(1, $urandom, $urandom, 2'($urandom));
            wait_resp(nresp + 1);
        end
        chk("solo_n", 32'(grants.size()), 32'd3);
        foreach (grants[k]) chk("solo_id", 32'(grants[k]), 32'd1);

        rsp_ready = 0;
        issue(0, 32'd9, 32'd4, 2'b01);
        for (int i = 0; i < 10 && !(busy && cyc >= hs_cyc + 2); i++) step();
        issue(1, 32'hF0, 32'h0F, 2'b11);
        repeat (4) step();
        rsp_ready = 1;
        t = nresp;
        wait_resp(t + 1);
        step();
        chk("bp_gap", 32'(hs_cyc - cons_cyc), 32'd1);
        chk("bp_next", 32'(grants[grants.size()-1]), 32'd1);
        wait_resp(nresp + 1);

        issue(1, 32'd1, 32'd2, 2'b00);
        t = grants.size();
        for (int i = 0; i < 10 && grants.size() == t; i++) step();
        apply_reset();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(0, 32'd7, 32'd8, 2'b10);
        issue(1, 32'd7, 32'd8, 2'b11);
        t = grants.size();
        for (int i = 0; i < 10 && grants.size() == t; i++) step();
        chk("mid_first", 32'(grants[grants.size()-1]), 32'd0);
        req1_valid = 0;
        wait_resp(nresp + 1);

        for (int i = 0; i < 600; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid && $urandom_range(0, 2) == 0)
                issue(0, rnd(), rnd(), 2'($urandom));
            else if (req0_valid && $urandom_range(0, 19) == 0)
                req0_valid = 0;
            if (!req1_valid && $urandom_range(0, 2) == 0)
                issue(1, rnd(), rnd(), 2'($urandom));
            else if (req1_valid && $urandom_range(0, 19) == 0)
                req1_valid = 0;
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        wait_resp(nresp + (busy ? 1 : 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
